// File: rtl/keypad_scan_ctrl.sv
// Keypad matrix scanner: one row driven low at a time, per-key
// scan-count debounce, press/release events through a FWFT FIFO.

module keypad_scan_ctrl #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SETTLE_CYCLES  = 64,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 4,
    localparam int NK = ROWS * COLS,
    localparam int KW = (NK > 1) ? $clog2(NK) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [ROWS-1:0] row_n,
    input  logic [COLS-1:0] col_n,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [KW-1:0]   evt_key,
    output logic            evt_pressed,
    output logic [NK-1:0]   key_state
);

    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW  = $clog2(SETTLE_CYCLES);
    localparam int CW  = $clog2(DEBOUNCE_SCANS + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_SETTLE,
        S_SAMPLE,
        S_EMIT
    } state_t;

    state_t          state_q, state_d;
    logic            run_q;
    logic [SW-1:0]   settle_q, settle_d;
    logic [RW-1:0]   r_q, r_d;
    logic [CLW-1:0]  c_q, c_d;
    logic [COLS-1:0] col_meta, col_sync;
    logic [CW-1:0]   cnt_q [NK];
    logic [KW-1:0]   k_idx;
    logic            pending;
    logic            push;
    logic            pop;
    logic            full;
    logic            can_push;

    logic [KW-1:0]         fifo_key [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_prs;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;

    assign k_idx    = KW'(int'(r_q) * COLS + int'(c_q));
    assign pending  = (cnt_q[k_idx] == CW'(DEBOUNCE_SCANS));
    assign evt_valid   = (count != '0);
    assign evt_key     = fifo_key[rd_ptr];
    assign evt_pressed = fifo_prs[rd_ptr];
    assign pop      = evt_valid & evt_ready;
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    // A pop on the same edge frees the slot, so a full FIFO need not stall
    assign can_push = !full || pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= col_n;
            col_sync <= col_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_SETTLE;
            run_q    <= 1'b0;
            settle_q <= '0;
            r_q      <= '0;
            c_q      <= '0;
            row_n    <= '1;
        end else begin
            state_q  <= state_d;
            run_q    <= 1'b1;
            settle_q <= settle_d;
            r_q      <= r_d;
            c_q      <= c_d;
            row_n    <= ~(ROWS'(1) << r_d);
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        r_d      = r_q;
        c_d      = c_q;
        push     = 1'b0;
        // First cycle out of reset only starts driving row 0
        if (run_q) begin
            unique case (state_q)
                S_SETTLE: begin
                    if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                        settle_d = '0;
                        state_d  = S_SAMPLE;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    c_d     = '0;
                    state_d = S_EMIT;
                end
                S_EMIT: begin
                    if (!pending || can_push) begin
                        push = pending;
                        if (c_q == CLW'(COLS - 1)) begin
                            c_d     = '0;
                            state_d = S_SETTLE;
                            if (r_q == RW'(ROWS - 1)) begin
                                r_d = '0;
                            end else begin
                                r_d = r_q + 1'b1;
                            end
                        end else begin
                            c_d = c_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_SETTLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NK; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NK; i++) begin
                if (state_q == S_SAMPLE && int'(r_q) == i / COLS) begin
                    if ((~col_sync[i % COLS]) == key_state[i]) begin
                        cnt_q[i] <= '0;
                    end else if (cnt_q[i] != CW'(DEBOUNCE_SCANS)) begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else if (push && int'(k_idx) == i) begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_state <= '0;
        end else if (push) begin
            key_state[k_idx] <= ~key_state[k_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_key[wr_ptr] <= k_idx;
            fifo_prs[wr_ptr] <= ~key_state[k_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
